bcd_to_bin: RTL and testbench
=============================

BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of packed BCD digits in bcd_in.
REQ-002 SHALL have parameter BIN_W, default 14: width of binary_out; BIN_W SHALL be >= ceil(log2(10^DIGITS)).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  conversion request, sampled each rising edge.
REQ-006 SHALL have port bcd_in  input  4*DIGITS  packed BCD operand, most significant digit in the top nibble.
REQ-007 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse when binary_out/err are updated.
REQ-009 SHALL have port binary_out  output  BIN_W  converted value, held between conversions.
REQ-010 SHALL have port err  output  1  high when the last conversion held a digit above 9; held with binary_out.

Function
REQ-011 SHALL implement a two-state FSM, IDLE and CONV, with all outputs registered.
REQ-012 SHALL accept start only on an edge where the FSM is in IDLE; on accept, latch bcd_in into a digit shift register, clear the accumulator, clear the digit counter and the invalid flag, and go to CONV.
REQ-013 SHALL ignore start while in CONV, with no effect on the latched operand or the outcome.
REQ-014 SHALL, on each CONV edge, compute acc <= acc*10 + top digit, formed as (acc<<3)+(acc<<1)+digit and truncated to BIN_W; then shift the digit register left 4 bits and increment the counter.
REQ-015 SHALL set the invalid flag on any CONV edge where the top digit exceeds 9.
REQ-016 SHALL process exactly DIGITS digits, most significant first: if start is accepted at edge E0, digits are consumed at edges E1..E_DIGITS.
REQ-017 SHALL, at edge E_DIGITS, load binary_out with the final accumulator and load err with the invalid flag.
REQ-018 SHALL also, at edge E_DIGITS, set done=1 for exactly one cycle, set busy=0 and return to IDLE.
REQ-019 SHALL, when the invalid flag is set at completion, drive binary_out=0 and err=1 instead of the accumulator value.
REQ-020 SHALL hold busy=1 from edge E0 through the cycle before edge E_DIGITS.
REQ-021 SHALL support back-to-back conversions: a start at edge E_DIGITS+1, while done is high, is accepted, giving one result per DIGITS+1 cycles.
REQ-022 SHALL leave binary_out and err unchanged except at a completion edge or at reset.
REQ-023 SHALL treat bcd_in as don't-care except on the accepting edge.

Reset
REQ-024 SHALL, when reset=1 at a rising edge, force the FSM to IDLE and clear busy, done, binary_out, err, the accumulator, the counter and the invalid flag to 0.
REQ-025 SHALL give reset priority over start and over any in-progress conversion.
REQ-026 SHALL, on reset asserted mid-conversion, discard the conversion: no done pulse is produced for it.
REQ-027 SHALL accept a start on the first edge after reset deasserts.

Verification
REQ-028 SHALL cover: start with bcd_in=16'h0039 at E0 -> done=1 after E4, binary_out=39, err=0, busy high only during E0..E3 cycles.
REQ-029 SHALL cover: bcd_in=16'h9999 -> binary_out=9999 (14'h270F), err=0; and bcd_in=16'h0000 -> binary_out=0, err=0.
REQ-030 SHALL cover: bcd_in=16'h12A4 -> done=1 after E4, err=1, binary_out=0; next conversion of 16'h0123 -> err=0, binary_out=123.
REQ-031 SHALL cover: start 16'h0042 at E0, then start 16'h0777 at E2 -> second start ignored, result 42, single done pulse.
REQ-032 SHALL cover: start 16'h1234, reset at E2 -> busy=0 and binary_out=0 after E2, no done pulse; start 16'h0058 at E3 -> 58 after E7.
REQ-033 SHALL cover: start held high continuously with bcd_in changing every cycle -> done every 5 cycles, each result matching bcd_in on its accepting edge.

Source files
------------

// File: rtl/bcd_to_bin.sv
// ---------------------------------------------------------------------------
// bcd_to_bin
// Sequential packed-BCD to binary converter. One digit is folded into the
// accumulator per clock (acc = acc*10 + digit, most significant digit first),
// so a DIGITS-digit operand takes DIGITS cycles after the accepting edge.
// A conversion that meets any nibble above 9 reports err=1 with a zero result.
//
// Parameters
//   DIGITS      number of packed BCD digits in bcd_in
//   BIN_W       width of binary_out; must hold 10**DIGITS - 1
//
// Ports
//   clk         sole clock, rising edge
//   reset       synchronous, active-high; wins over start and any conversion
//   start       conversion request, honoured only while idle
//   bcd_in      packed BCD operand, most significant digit in the top nibble
//   busy        high while a conversion is in progress
//   done        one-cycle pulse on the edge binary_out/err are updated
//   binary_out  converted value, held between conversions
//   err         last conversion held a digit above 9, held with binary_out
// ---------------------------------------------------------------------------
module bcd_to_bin #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      binary_out,
    output logic                  err
);

    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned CNT_W  = $clog2(DIGITS + 1);
    localparam int unsigned LAST_D = DIGITS - 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t               state_q;
    state_t               state_d;

    logic [BCD_W-1:0]     shreg_q;
    logic [BCD_W-1:0]     shreg_d;
    logic [BIN_W-1:0]     acc_q;
    logic [BIN_W-1:0]     acc_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic                 inv_q;
    logic                 inv_d;
    logic                 busy_d;
    logic                 done_d;
    logic [BIN_W-1:0]     bin_d;
    logic                 err_d;

    logic [3:0]           digit;
    logic                 digit_bad;
    logic                 last_digit;
    logic [BIN_W-1:0]     acc_mac;

    // Digit currently at the head of the shift register
    assign digit      = shreg_q[BCD_W-1 -: 4];
    assign digit_bad  = (digit > 4'd9);
    assign last_digit = (cnt_q == CNT_W'(LAST_D));

    // acc*10 + digit as shift-and-add, wrapping at BIN_W
    assign acc_mac = (acc_q << 3) + (acc_q << 1) + BIN_W'(digit);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CONV;
                end
            end
            CONV: begin
                if (last_digit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        shreg_d = shreg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        inv_d   = inv_q;
        busy_d  = busy;
        done_d  = 1'b0;
        bin_d   = binary_out;
        err_d   = err;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d = bcd_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    inv_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            CONV: begin
                acc_d   = acc_mac;
                shreg_d = shreg_q << 4;
                cnt_d   = cnt_q + CNT_W'(1);
                inv_d   = inv_q | digit_bad;
                if (last_digit) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    err_d  = inv_d;
                    // An invalid operand never exposes a partial value
                    bin_d  = inv_d ? '0 : acc_mac;
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            inv_q      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            binary_out <= '0;
            err        <= 1'b0;
        end else begin
            shreg_q    <= shreg_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            inv_q      <= inv_d;
            busy       <= busy_d;
            done       <= done_d;
            binary_out <= bin_d;
            err        <= err_d;
        end
    end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed self-checking bench for bcd_to_bin (DIGITS=4, BIN_W=14).
module tb_bcd_to_bin;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] bcd_in;
    logic        busy;
    logic        done;
    logic [13:0] binary_out;
    logic        err;

    int n_assert = 0;
    int n_fail   = 0;

    bcd_to_bin #(.DIGITS(4), .BIN_W(14)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bcd_in     (bcd_in),
        .busy       (busy),
        .done       (done),
        .binary_out (binary_out),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs changed afterwards land on the next edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Full conversion starting at the next edge (E0), result checked after E4
    task automatic conv(input logic [15:0] bcd, input int exp_bin, input logic exp_err,
                        input string tag);
        start  = 1'b1;
        bcd_in = bcd;
        tick();
        start  = 1'b0;
        bcd_in = 16'($urandom);
        chk({tag, " busy@E0"}, 32'(busy), 32'd1);
        chk({tag, " done@E0"}, 32'(done), 32'd0);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk({tag, " busy@mid"}, 32'(busy), 32'd1);
            chk({tag, " done@mid"}, 32'(done), 32'd0);
        end
        tick();
        chk({tag, " done@E4"}, 32'(done), 32'd1);
        chk({tag, " busy@E4"}, 32'(busy), 32'd0);
        chk({tag, " bin@E4"},  32'(binary_out), 32'(exp_bin));
        chk({tag, " err@E4"},  32'(err), 32'(exp_err));
    endtask

    logic [15:0] vec [15];
    int          exp_b2b [3];

    initial begin
        reset  = 1'b1;
        start  = 1'b1;
        bcd_in = 16'h0777;

        // Reset with start asserted: reset wins
        tick();
        tick();
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst bin",  32'(binary_out), 32'd0);
        chk("rst err",  32'(err), 32'd0);

        // Start accepted on the first edge after reset deasserts
        reset = 1'b0;
        conv(16'h0039, 39, 1'b0, "c0039");
        tick();
        chk("c0039 done low after", 32'(done), 32'd0);
        chk("c0039 busy low after", 32'(busy), 32'd0);
        chk("c0039 bin held",       32'(binary_out), 32'd39);

        conv(16'h9999, 9999, 1'b0, "c9999");
        conv(16'h0000, 0,    1'b0, "c0000");

        // Invalid digit, then a clean conversion back-to-back
        conv(16'h12A4, 0,   1'b1, "c12A4");
        conv(16'h0123, 123, 1'b0, "c0123");

        // Error result is held across idle cycles
        conv(16'h10B0, 0, 1'b1, "c10B0");
        tick();
        tick();
        chk("err held",     32'(err), 32'd1);
        chk("err bin held", 32'(binary_out), 32'd0);

        // Start during CONV is ignored
        start  = 1'b1;
        bcd_in = 16'h0042;
        tick();                       // E0
        start  = 1'b0;
        bcd_in = 16'h0000;
        tick();                       // E1
        start  = 1'b1;
        bcd_in = 16'h0777;
        tick();                       // E2
        start  = 1'b0;
        chk("ign busy@E2", 32'(busy), 32'd1);
        tick();                       // E3
        chk("ign done@E3", 32'(done), 32'd0);
        tick();                       // E4
        chk("ign done@E4", 32'(done), 32'd1);
        chk("ign bin@E4",  32'(binary_out), 32'd42);
        chk("ign err@E4",  32'(err), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("ign no 2nd done", 32'(done), 32'd0);
            chk("ign no 2nd busy", 32'(busy), 32'd0);
        end
        chk("ign bin held", 32'(binary_out), 32'd42);

        // Reset mid-conversion discards it
        start  = 1'b1;
        bcd_in = 16'h1234;
        tick();                       // E0
        start  = 1'b0;
        tick();                       // E1
        reset  = 1'b1;
        tick();                       // E2
        chk("mrst busy", 32'(busy), 32'd0);
        chk("mrst bin",  32'(binary_out), 32'd0);
        chk("mrst done", 32'(done), 32'd0);
        reset  = 1'b0;
        start  = 1'b1;
        bcd_in = 16'h0058;
        tick();                       // E3
        start  = 1'b0;
        chk("mrst busy@E3", 32'(busy), 32'd1);
        for (int i = 4; i < 7; i++) begin
            tick();
            chk("mrst no done", 32'(done), 32'd0);
        end
        tick();                       // E7
        chk("mrst done@E7", 32'(done), 32'd1);
        chk("mrst bin@E7",  32'(binary_out), 32'd58);
        chk("mrst err@E7",  32'(err), 32'd0);

        // Start held high, operand changing every cycle: accepts at 0, 5, 10
        vec = '{16'h2468, 16'hFFFF, 16'h1111, 16'h9999, 16'hABCD,
                16'h0507, 16'h3333, 16'hFA00, 16'h0001, 16'h7777,
                16'h8000, 16'h4444, 16'hEEEE, 16'h0909, 16'h5555};
        exp_b2b = '{2468, 507, 8000};
        start = 1'b1;
        for (int c = 0; c < 15; c++) begin
            bcd_in = vec[c];
            tick();
            if (c == 14) start = 1'b0;
            chk("b2b done", 32'(done), ((c % 5) == 4) ? 32'd1 : 32'd0);
            if ((c % 5) == 4) begin
                chk("b2b bin", 32'(binary_out), 32'(exp_b2b[c / 5]));
                chk("b2b err", 32'(err), 32'd0);
            end
        end
        tick();
        chk("b2b idle after", 32'(busy), 32'd0);
        chk("b2b bin held",   32'(binary_out), 32'd8000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
